// File: rtl/lightgun_latch.sv
// Light-gun receiver: synchronises the sensor and buttons, filters the sensor pulse and latches
// the raster position on the first valid hit of each frame. Optional IRQ port: LIGHTGUN_LATCH_IRQ_EN.

module lightgun_latch #(
  parameter int unsigned       MIN_PULSE = 4,
  parameter logic signed [9:0] H_OFFSET  = 10'sd0,
  parameter logic signed [8:0] V_OFFSET  = 9'sd0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CE_PIX,
  input  logic       HDE,
  input  logic       VDE,
  input  logic       SENSOR,
  input  logic       BTN_TRIG,
  input  logic       BTN_START,
  input  logic       LATCH_EN,
  input  logic       RD_REQ,
  output logic [9:0] HCNT_LAT,
  output logic [8:0] VCNT_LAT,
  output logic       LAT_FLAG,
  output logic       RD_ACK,
  output logic       TRIG,
`ifdef LIGHTGUN_LATCH_IRQ_EN
  output logic       START,
  input  logic       IRQ_MASK,
  output logic       IRQ
`else
  output logic       START
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEASURE,
    S_COMMIT,
    S_WAIT_LOW
  } state_t;

  localparam logic [3:0] MIN_W = 4'(MIN_PULSE);

  logic       sensor_meta, sensor_sync;
  logic       trig_meta, start_meta;
  logic [9:0] hcnt;
  logic [8:0] vcnt;
  logic       hde_q, vde_q;
  logic       vde_rise;
  logic       taken;
  state_t     state, state_nxt;
  logic [3:0] width, width_nxt, width_inc;
  logic       snap;
  logic       commit;
  logic [9:0] cand_h;
  logic [8:0] cand_v;
  logic signed [11:0] h_adj;
  logic signed [10:0] v_adj;
  logic [9:0] h_lat_nxt;
  logic [8:0] v_lat_nxt;

  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sensor_meta <= 1'b0;
      sensor_sync <= 1'b0;
      trig_meta   <= 1'b0;
      TRIG        <= 1'b0;
      start_meta  <= 1'b0;
      START       <= 1'b0;
    end else begin
      sensor_meta <= SENSOR;
      sensor_sync <= sensor_meta;
      trig_meta   <= BTN_TRIG;
      TRIG        <= trig_meta;
      start_meta  <= BTN_START;
      START       <= start_meta;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hcnt  <= '0;
      vcnt  <= '0;
      hde_q <= 1'b0;
      vde_q <= 1'b0;
    end else if (CE_PIX) begin
      hde_q <= HDE;
      vde_q <= VDE;
      if (!HDE) hcnt <= '0;
      else if (hcnt != 10'h3FF) hcnt <= hcnt + 10'd1;
      if (!VDE) vcnt <= '0;
      else if (hde_q && !HDE && vcnt != 9'h1FF) vcnt <= vcnt + 9'd1;
    end
  end

  assign vde_rise  = CE_PIX && VDE && !vde_q;
  assign width_inc = (width == 4'd15) ? width : width + 4'd1;
  assign commit    = (state == S_COMMIT) && LATCH_EN;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    width_nxt = width;
    snap      = 1'b0;
    unique case (state)
      S_IDLE:
        if (CE_PIX && sensor_sync && !taken && HDE && VDE) begin
          snap      = 1'b1;
          width_nxt = 4'd1;
          state_nxt = (MIN_W <= 4'd1) ? S_COMMIT : S_MEASURE;
        end
      S_MEASURE:
        if (CE_PIX) begin
          if (!sensor_sync) begin
            state_nxt = S_IDLE;
          end else begin
            width_nxt = width_inc;
            if (width_inc == MIN_W) state_nxt = S_COMMIT;
          end
        end
      S_COMMIT:   state_nxt = S_WAIT_LOW;
      S_WAIT_LOW: if (CE_PIX && !sensor_sync) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
    if (!LATCH_EN) begin
      state_nxt = S_IDLE;
      snap      = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= S_IDLE;
      width  <= '0;
      cand_h <= '0;
      cand_v <= '0;
      taken  <= 1'b0;
    end else begin
      state <= state_nxt;
      width <= width_nxt;
      if (snap) begin
        cand_h <= hcnt;
        cand_v <= vcnt;
      end
      if (commit) taken <= 1'b1;
      else if (vde_rise) taken <= 1'b0;
    end
  end

  // Offset correction in two extra bits: negative results clamp to 0, overflow saturates.
  assign h_adj     = $signed({2'b00, cand_h}) - $signed({{2{H_OFFSET[9]}}, H_OFFSET});
  assign v_adj     = $signed({2'b00, cand_v}) - $signed({{2{V_OFFSET[8]}}, V_OFFSET});
  assign h_lat_nxt = h_adj[11] ? 10'd0 : (h_adj[10] ? 10'h3FF : h_adj[9:0]);
  assign v_lat_nxt = v_adj[10] ? 9'd0 : (v_adj[9] ? 9'h1FF : v_adj[8:0]);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      HCNT_LAT <= '0;
      VCNT_LAT <= '0;
      LAT_FLAG <= 1'b0;
      RD_ACK   <= 1'b0;
    end else begin
      RD_ACK <= RD_REQ;
      if (commit) begin
        HCNT_LAT <= h_lat_nxt;
        VCNT_LAT <= v_lat_nxt;
        LAT_FLAG <= 1'b1;
      end else if (RD_REQ) begin
        LAT_FLAG <= 1'b0;
      end
    end
  end

`ifdef LIGHTGUN_LATCH_IRQ_EN
  assign IRQ = commit && !IRQ_MASK;
`endif

endmodule

// File: tb/tb_lightgun_latch.sv
// Directed bench for lightgun_latch: one instance with zero offsets, one with H_OFFSET=5/V_OFFSET=2,
// both driven by the same pixel stream (3 CLK per pixel, CE_PIX on the last).

module tb_lightgun_latch;

  logic clk = 1'b0;
  logic rst, ce_pix, hde, vde, sensor, btn_trig, btn_start, latch_en, rd_req;
  logic [9:0] hcnt0, hcnt1;
  logic [8:0] vcnt0, vcnt1;
  logic flag0, flag1, ack0, ack1, trig0, trig1, start0, start1;
  int tests = 0;
  int fails = 0;

`ifdef LIGHTGUN_LATCH_IRQ_EN
  logic irq_mask;
  logic irq0, irq1;
  int   irq_cnt = 0;
  always @(negedge clk) if (irq0 === 1'b1) irq_cnt++;
`endif

  always #5 clk = ~clk;

  lightgun_latch dut0 (
    .CLK(clk),
`ifdef LIGHTGUN_LATCH_IRQ_EN
    .IRQ_MASK(irq_mask), .IRQ(irq0),
`endif
    .RESET(rst), .CE_PIX(ce_pix), .HDE(hde), .VDE(vde), .SENSOR(sensor),
    .BTN_TRIG(btn_trig), .BTN_START(btn_start), .LATCH_EN(latch_en), .RD_REQ(rd_req),
    .HCNT_LAT(hcnt0), .VCNT_LAT(vcnt0), .LAT_FLAG(flag0), .RD_ACK(ack0),
    .TRIG(trig0), .START(start0)
  );

  lightgun_latch #(.MIN_PULSE(4), .H_OFFSET(10'sd5), .V_OFFSET(9'sd2)) dut1 (
    .CLK(clk),
`ifdef LIGHTGUN_LATCH_IRQ_EN
    .IRQ_MASK(irq_mask), .IRQ(irq1),
`endif
    .RESET(rst), .CE_PIX(ce_pix), .HDE(hde), .VDE(vde), .SENSOR(sensor),
    .BTN_TRIG(btn_trig), .BTN_START(btn_start), .LATCH_EN(latch_en), .RD_REQ(rd_req),
    .HCNT_LAT(hcnt1), .VCNT_LAT(vcnt1), .LAT_FLAG(flag1), .RD_ACK(ack1),
    .TRIG(trig1), .START(start1)
  );

  // One pixel: inputs change at a negedge, the synchroniser settles, then one CE_PIX edge.
  task automatic pix(input logic h, input logic v, input logic s);
    hde = h; vde = v; sensor = s; ce_pix = 1'b0;
    repeat (2) @(negedge clk);
    ce_pix = 1'b1;
    @(negedge clk);
    ce_pix = 1'b0;
  endtask

  // Active line of 'width' pixels with the sensor high for pixels x..x+len-1, then one blank pixel.
  task automatic line(input int width, input int x, input int len);
    for (int i = 0; i < width; i++) pix(1'b1, 1'b1, (i >= x) && (i < x + len));
    pix(1'b0, 1'b1, 1'b0);
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) line(1, 0, 0);
  endtask

  task automatic frame_start();
    pix(1'b0, 1'b0, 1'b0);
    pix(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; ce_pix = 1'b0; hde = 1'b0; vde = 1'b0; sensor = 1'b0;
    btn_trig = 1'b0; btn_start = 1'b0; latch_en = 1'b1; rd_req = 1'b0;
`ifdef LIGHTGUN_LATCH_IRQ_EN
    irq_mask = 1'b0;
`endif
    repeat (3) @(negedge clk);
    tests++;
    if ({hcnt0, vcnt0, flag0, ack0, trig0, start0} !== 23'd0) begin
      fails++; $display("FAIL reset_dut0: got %h expected 0", {hcnt0, vcnt0, flag0, ack0, trig0, start0});
    end
    tests++;
    if ({hcnt1, vcnt1, flag1, ack1, trig1, start1} !== 23'd0) begin
      fails++; $display("FAIL reset_dut1: got %h expected 0", {hcnt1, vcnt1, flag1, ack1, trig1, start1});
    end
`ifdef LIGHTGUN_LATCH_IRQ_EN
    tests++;
    if ({irq0, irq1} !== 2'b00) begin fails++; $display("FAIL reset_irq: got %b expected 00", {irq0, irq1}); end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sync();
    btn_trig = 1'b1;
    @(negedge clk);
    tests++; if (trig0 !== 1'b0) begin fails++; $display("FAIL trig_lat1: got %b expected 0", trig0); end
    @(negedge clk);
    tests++; if (trig0 !== 1'b1) begin fails++; $display("FAIL trig_lat2: got %b expected 1", trig0); end
    tests++; if (start0 !== 1'b0) begin fails++; $display("FAIL start_quiet: got %b expected 0", start0); end
    btn_trig = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (trig0 !== 1'b0) begin fails++; $display("FAIL trig_release: got %b expected 0", trig0); end
    btn_start = 1'b1;
    @(negedge clk);
    tests++; if (start0 !== 1'b0) begin fails++; $display("FAIL start_lat1: got %b expected 0", start0); end
    @(negedge clk);
    tests++; if (start0 !== 1'b1) begin fails++; $display("FAIL start_lat2: got %b expected 1", start0); end
    tests++; if (trig0 !== 1'b0) begin fails++; $display("FAIL trig_quiet: got %b expected 0", trig0); end
    btn_start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_hit();
`ifdef LIGHTGUN_LATCH_IRQ_EN
    irq_cnt = 0;
`endif
    frame_start(); lines(50); line(320, 100, 6);
    tests++; if (hcnt0 !== 10'd100) begin fails++; $display("FAIL basic_h: got %0d expected 100", hcnt0); end
    tests++; if (vcnt0 !== 9'd50) begin fails++; $display("FAIL basic_v: got %0d expected 50", vcnt0); end
    tests++; if (flag0 !== 1'b1) begin fails++; $display("FAIL basic_flag: got %b expected 1", flag0); end
    tests++; if (hcnt1 !== 10'd95) begin fails++; $display("FAIL basic_h_off: got %0d expected 95", hcnt1); end
    tests++; if (vcnt1 !== 9'd48) begin fails++; $display("FAIL basic_v_off: got %0d expected 48", vcnt1); end
`ifdef LIGHTGUN_LATCH_IRQ_EN
    tests++; if (irq_cnt != 1) begin fails++; $display("FAIL basic_irq_cycles: got %0d expected 1", irq_cnt); end
`endif
  endtask

  task automatic test_read();
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    tests++; if (ack0 !== 1'b1) begin fails++; $display("FAIL read_ack: got %b expected 1", ack0); end
    tests++; if (flag0 !== 1'b0) begin fails++; $display("FAIL read_flag: got %b expected 0", flag0); end
    tests++; if ({hcnt0, vcnt0} !== {10'd100, 9'd50}) begin
      fails++; $display("FAIL read_values: got %0d,%0d expected 100,50", hcnt0, vcnt0);
    end
    @(negedge clk);
    tests++; if (ack0 !== 1'b0) begin fails++; $display("FAIL read_ack_once: got %b expected 0", ack0); end
    rd_req = 1'b1;
    @(negedge clk);
    tests++; if (ack0 !== 1'b1) begin fails++; $display("FAIL b2b_ack1: got %b expected 1", ack0); end
    @(negedge clk);
    rd_req = 1'b0;
    tests++; if (ack0 !== 1'b1) begin fails++; $display("FAIL b2b_ack2: got %b expected 1", ack0); end
    @(negedge clk);
    tests++; if (ack0 !== 1'b0) begin fails++; $display("FAIL b2b_ack_end: got %b expected 0", ack0); end
  endtask

  task automatic test_glitch();
    frame_start(); lines(80); line(320, 200, 3);
    tests++; if (flag0 !== 1'b0) begin fails++; $display("FAIL glitch_flag: got %b expected 0", flag0); end
    line(320, 210, 5);
    tests++; if (hcnt0 !== 10'd210) begin fails++; $display("FAIL glitch_next_h: got %0d expected 210", hcnt0); end
    tests++; if (vcnt0 !== 9'd81) begin fails++; $display("FAIL glitch_next_v: got %0d expected 81", vcnt0); end
    tests++; if (flag0 !== 1'b1) begin fails++; $display("FAIL glitch_next_flag: got %b expected 1", flag0); end
  endtask

  task automatic test_one_per_frame();
    frame_start(); lines(40); line(64, 30, 8); lines(19); line(64, 30, 8);
    tests++; if (vcnt0 !== 9'd40) begin fails++; $display("FAIL frame_first_v: got %0d expected 40", vcnt0); end
    tests++; if (hcnt0 !== 10'd30) begin fails++; $display("FAIL frame_first_h: got %0d expected 30", hcnt0); end
    frame_start(); lines(60); line(64, 31, 8);
    tests++; if (vcnt0 !== 9'd60) begin fails++; $display("FAIL rearm_v: got %0d expected 60", vcnt0); end
    tests++; if (hcnt0 !== 10'd31) begin fails++; $display("FAIL rearm_h: got %0d expected 31", hcnt0); end
    tests++; if (flag0 !== 1'b1) begin fails++; $display("FAIL rearm_flag: got %b expected 1", flag0); end
  endtask

  task automatic test_collision();
    frame_start(); lines(10);
    for (int i = 0; i < 12; i++) pix(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) pix(1'b1, 1'b1, 1'b1);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    tests++; if (ack0 !== 1'b1) begin fails++; $display("FAIL collide_ack: got %b expected 1", ack0); end
    tests++; if (flag0 !== 1'b1) begin fails++; $display("FAIL collide_flag: got %b expected 1", flag0); end
    tests++; if ({hcnt0, vcnt0} !== {10'd12, 9'd10}) begin
      fails++; $display("FAIL collide_values: got %0d,%0d expected 12,10", hcnt0, vcnt0);
    end
    for (int i = 0; i < 3; i++) pix(1'b1, 1'b1, 1'b0);
    pix(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_offsets();
    frame_start(); lines(1); line(16, 3, 5);
    tests++; if ({hcnt1, vcnt1} !== {10'd0, 9'd0}) begin
      fails++; $display("FAIL clamp_values: got %0d,%0d expected 0,0", hcnt1, vcnt1);
    end
    tests++; if (flag1 !== 1'b1) begin fails++; $display("FAIL clamp_flag: got %b expected 1", flag1); end
    tests++; if ({hcnt0, vcnt0} !== {10'd3, 9'd1}) begin
      fails++; $display("FAIL clamp_ref: got %0d,%0d expected 3,1", hcnt0, vcnt0);
    end
    frame_start(); lines(20); line(64, 50, 5);
    tests++; if ({hcnt1, vcnt1} !== {10'd45, 9'd18}) begin
      fails++; $display("FAIL offset_values: got %0d,%0d expected 45,18", hcnt1, vcnt1);
    end
    tests++; if ({hcnt0, vcnt0} !== {10'd50, 9'd20}) begin
      fails++; $display("FAIL offset_ref: got %0d,%0d expected 50,20", hcnt0, vcnt0);
    end
  endtask

  task automatic test_latch_en();
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    latch_en = 1'b0;
    frame_start(); lines(5); line(32, 10, 6);
    latch_en = 1'b1;
    tests++; if (flag0 !== 1'b0) begin fails++; $display("FAIL disabled_flag: got %b expected 0", flag0); end
    tests++; if ({hcnt0, vcnt0} !== {10'd50, 9'd20}) begin
      fails++; $display("FAIL disabled_hold: got %0d,%0d expected 50,20", hcnt0, vcnt0);
    end
    frame_start(); lines(6);
    for (int i = 0; i < 10; i++) pix(1'b1, 1'b1, 1'b0);
    pix(1'b1, 1'b1, 1'b1); pix(1'b1, 1'b1, 1'b1);
    latch_en = 1'b0;
    for (int i = 0; i < 4; i++) pix(1'b1, 1'b1, 1'b1);
    latch_en = 1'b1;
    for (int i = 0; i < 4; i++) pix(1'b1, 1'b1, 1'b0);
    pix(1'b0, 1'b1, 1'b0);
    tests++; if (flag0 !== 1'b0) begin fails++; $display("FAIL abort_flag: got %b expected 0", flag0); end
  endtask

  task automatic test_outside();
    for (int i = 0; i < 6; i++) pix(1'b0, 1'b0, 1'b1);
    pix(1'b0, 1'b0, 1'b0);
    lines(3);
    for (int i = 0; i < 6; i++) pix(1'b0, 1'b1, 1'b1);
    pix(1'b0, 1'b1, 1'b0);
    line(16, 0, 0);
    tests++; if (flag0 !== 1'b0) begin fails++; $display("FAIL outside_flag: got %b expected 0", flag0); end
  endtask

  task automatic test_reset_mid_hit();
`ifdef LIGHTGUN_LATCH_IRQ_EN
    irq_cnt = 0;
`endif
    frame_start(); lines(3);
    for (int i = 0; i < 5; i++) pix(1'b1, 1'b1, 1'b0);
    pix(1'b1, 1'b1, 1'b1); pix(1'b1, 1'b1, 1'b1);
    sensor = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if ({hcnt0, vcnt0, flag0} !== 20'd0) begin
      fails++; $display("FAIL midreset_clear: got %0d,%0d,%b expected 0,0,0", hcnt0, vcnt0, flag0);
    end
    for (int i = 0; i < 4; i++) pix(1'b1, 1'b1, 1'b0);
    pix(1'b0, 1'b1, 1'b0);
    tests++; if (flag0 !== 1'b0) begin fails++; $display("FAIL midreset_nolatch: got %b expected 0", flag0); end
`ifdef LIGHTGUN_LATCH_IRQ_EN
    tests++; if (irq_cnt != 0) begin fails++; $display("FAIL midreset_irq: got %0d expected 0", irq_cnt); end
`endif
  endtask

`ifdef LIGHTGUN_LATCH_IRQ_EN
  task automatic test_irq_mask();
    irq_mask = 1'b1;
    irq_cnt  = 0;
    frame_start(); lines(2); line(16, 4, 6);
    irq_mask = 1'b0;
    tests++; if (irq_cnt != 0) begin fails++; $display("FAIL masked_irq: got %0d expected 0", irq_cnt); end
    tests++; if (flag0 !== 1'b1) begin fails++; $display("FAIL masked_flag: got %b expected 1", flag0); end
  endtask
`endif

  initial begin
    #600000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sync();
    test_basic_hit();
    test_read();
    test_glitch();
    test_one_per_frame();
    test_collision();
    test_offsets();
    test_latch_en();
    test_outside();
    test_reset_mid_hit();
`ifdef LIGHTGUN_LATCH_IRQ_EN
    test_irq_mask();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
